sm_stats_scheduler: RTL and testbench
=====================================

Name: sm_stats_scheduler

Overview:
- Consumes the decoded per-transfer strobes (enable[3:0], ep) from the surveillance module input decoder.
- Accumulates per-path and per-TDM-endpoint transfer counts over a programmable sampling interval.
- At each interval end, snapshots and clears the counts, then sequences them out as a 32-bit word stream over a valid/ready handshake.
- Sits between the decoder and the surveillance module's debug/trace packetizer.

Parameters:
- NUM_TDM_ENDPOINTS, 4, number of TDM endpoints monitored; ENDP_WIDTH = NUM_TDM_ENDPOINTS > 1 ? $clog2(NUM_TDM_ENDPOINTS) : 1
- CNT_WIDTH, 16, width of each event counter; legal range 1..24
- NUM_CNT (localparam), 2 + 2*NUM_TDM_ENDPOINTS, total counters; must be ≤ 256

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  4  one-cycle event strobes: [0] be_send, [1] be_receive, [2] tdm_send, [3] tdm_receive; at most one bit set per cycle
- ep  in  ENDP_WIDTH  TDM endpoint index, valid when enable[2] or enable[3] is set
- period  in  32  sampling interval in clk cycles; 0 disables sampling
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  32  output word
- busy  out  1  high while a snapshot is being emitted

Behaviour:
- Live counters, index order: 0 = be_send, 1 = be_receive, then for endpoint e: 2+2e = tdm_send[e], 3+2e = tdm_receive[e].
- Each enable strobe increments the selected counter by 1. Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- ep ≥ NUM_TDM_ENDPOINTS: TDM strobe ignored.
- Interval timer:
  - 32 bits, increments every cycle while period != 0.
  - When timer == period-1: timer returns to 0 and `tick` is asserted for that cycle.
  - period == 0: timer held at 0, no ticks.
  - period is sampled continuously. If timer ≥ new period-1 after a change, the tick fires on the next cycle.
- Tick in IDLE:
  - All live counters are copied to shadow registers at the clock edge ending the tick cycle.
  - Live counters are cleared at the same edge.
  - A strobe arriving in the tick cycle is counted in the new interval (counter becomes 1), not in the snapshot.
- Tick while not IDLE:
  - Snapshot is skipped and live counters keep accumulating (no clear).
  - The overrun flag is set and held until the next emitted header carries it; it clears when that header is accepted.
- FSM:
  - IDLE: out_valid=0, busy=0. On tick → HDR.
  - HDR: out_valid=1; out_data = {4'hA, overrun, 11'b0, seq[15:0]}. On out_valid&out_ready: seq++ (wraps 0xFFFF→0), overrun cleared, idx=0 → DATA.
  - DATA: out_valid=1; out_data = {idx[7:0], zero-extended shadow[idx] to 24 bits}. On handshake: if idx == NUM_CNT-1 → IDLE, else idx++.
- Latency: header valid in the cycle after the tick cycle. One word per cycle with out_ready held high. A snapshot is 1+NUM_CNT words.
- Handshake rules:
  - out_data stable while out_valid && !out_ready.
  - out_valid is never dropped before acceptance.
  - No combinational path from out_ready to out_valid.
- busy = (state != IDLE).
- Reset values:
  - out_valid=0, busy=0, out_data=0, state=IDLE.
  - Live counters, shadow registers, timer, seq, idx and overrun all 0.
- Reset mid-emission: aborts immediately, no further words, seq restarts at 0.

Test Plan:
- NUM_TDM_ENDPOINTS=4, period=100, 3 be_send, 2 tdm_send ep=1, 5 tdm_receive ep=3 in interval → header 0xA0000000, words 0x00000003, 0x01000000, 0x02000000, 0x03000000, 0x04000002, 0x05000000, ..., 0x09000005; next header seq=1 (0xA0000001).
- CNT_WIDTH=4, 20 be_receive strobes in one interval → word 0x0100000F (saturated).
- tdm_send ep=0 asserted exactly in the tick cycle → current snapshot idx2 = 0; next snapshot idx2 = 1.
- period=10, out_ready held low for 40 cycles → out_data stays 0xA0000000 while stalled. After release, the following header has bit27 set (0xA8000001), and counts span both intervals.
- period=0 with strobes applied for 1000 cycles → out_valid never asserts. Then period=5 → header appears within 6 cycles and carries the accumulated counts.
- rst asserted while in DATA at idx=3 → next cycle out_valid=0, busy=0. After the next tick, header seq=0.

Source files
------------

// File: rtl/sm_stats_scheduler.sv
// Surveillance statistics scheduler: counts decoder strobes per sampling interval,
// snapshots them on each interval tick and streams header + counter words downstream.
module sm_stats_scheduler #(
    parameter int NUM_TDM_ENDPOINTS = 4,
    parameter int CNT_WIDTH         = 16,
    localparam int ENDP_WIDTH       = (NUM_TDM_ENDPOINTS > 1) ? $clog2(NUM_TDM_ENDPOINTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            enable,
    input  logic [ENDP_WIDTH-1:0] ep,
    input  logic [31:0]           period,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  busy
);
    localparam int NUM_CNT = 2 + 2 * NUM_TDM_ENDPOINTS;
    localparam logic [7:0] LAST_IDX = 8'(NUM_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t               state_q, state_d;
    logic [31:0]          timer_q, timer_d;
    logic [15:0]          seq_q, seq_d;
    logic [7:0]           idx_q, idx_d;
    logic                 overrun_q, overrun_d;
    logic                 ovr_hdr_q, ovr_hdr_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] live_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] live_d [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
    logic [NUM_CNT-1:0]   hit;
    logic                 tick, snap, hs;

    assign out_valid = (state_q != S_IDLE);
    assign busy      = out_valid;
    assign out_data  = out_data_q;
    assign hs        = out_valid && out_ready;
    // >= rather than == so a period shrunk below the running timer still ticks
    assign tick      = (period != 32'd0) && (timer_q >= period - 32'd1);
    assign snap      = tick && (state_q == S_IDLE);

    function automatic logic [23:0] shadow_word(input logic [7:0] k);
        logic [23:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (k == 8'(i)) sel = 24'(shadow_q[i]);
        return sel;
    endfunction

    always_comb begin
        hit    = '0;
        hit[0] = enable[0];
        hit[1] = enable[1];
        for (int e = 0; e < NUM_TDM_ENDPOINTS; e++) begin
            if (int'(ep) == e) begin
                hit[2 + 2 * e] = enable[2];
                hit[3 + 2 * e] = enable[3];
            end
        end
    end

    // A strobe in the snapshot cycle lands in the freshly cleared interval
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            live_d[i] = snap ? '0 : live_q[i];
            if (hit[i] && (live_d[i] != CNT_MAX)) live_d[i] = live_d[i] + CNT_WIDTH'(1);
            shadow_d[i] = snap ? live_q[i] : shadow_q[i];
        end
    end

    always_comb begin
        timer_d = ((period == 32'd0) || tick) ? 32'd0 : timer_q + 32'd1;
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;
        ovr_hdr_d  = ovr_hdr_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d    = S_HDR;
                    out_data_d = {4'hA, overrun_q, 11'b0, seq_q};
                    ovr_hdr_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d    = S_DATA;
                    seq_d      = seq_q + 16'd1;
                    idx_d      = 8'd0;
                    // overruns that hit while this header was stalled were not carried by it
                    overrun_d  = ovr_hdr_q;
                    out_data_d = {8'd0, shadow_word(8'd0)};
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        out_data_d = 32'd0;
                    end else begin
                        idx_d      = idx_q + 8'd1;
                        out_data_d = {idx_q + 8'd1, shadow_word(idx_q + 8'd1)};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
            ovr_hdr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            seq_q      <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            ovr_hdr_q  <= 1'b0;
            out_data_q <= '0;
            live_q     <= '{default: '0};
            shadow_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            overrun_q  <= overrun_d;
            ovr_hdr_q  <= ovr_hdr_d;
            out_data_q <= out_data_d;
            live_q     <= live_d;
            shadow_q   <= shadow_d;
        end
    end
endmodule

// File: tb/tb_sm_stats_scheduler.sv
// Bench for sm_stats_scheduler: directed scenarios plus random traffic, checked against
// a snapshot-queue reference model; a CNT_WIDTH=4 instance shares the stimulus.
module tb_sm_stats_scheduler;
    localparam int NE = 4;
    localparam int NC = 2 + 2 * NE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  enable = '0;
    logic [1:0]  ep = '0;
    logic [31:0] period = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, busy, out_valid4, busy4;
    logic [31:0] out_data, out_data4;

    always #5 clk = ~clk;

    sm_stats_scheduler #(.NUM_TDM_ENDPOINTS(NE), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ep(ep), .period(period),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

    sm_stats_scheduler #(.NUM_TDM_ENDPOINTS(NE), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .ep(ep), .period(period),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4));

    int ntest = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: each snapshot becomes a list of expected words; raw counts are
    // kept unbounded and clipped to the counter width only when compared.
    typedef struct packed { logic hdr; logic [31:0] w; } ent_t;
    ent_t        mq[$];
    int unsigned m_cnt [NC];
    logic [31:0] m_timer = '0;
    logic [15:0] m_seq = '0;
    bit          m_ovr = 0, m_ovr_new = 0, m_fresh = 1;
    logic [31:0] cap[$], cap4[$];

    function automatic logic [31:0] expw(input ent_t e, input int w);
        int unsigned c, mx;
        if (e.hdr) return e.w;
        c  = e.w[23:0];
        mx = (32'd1 << w) - 1;
        if (c > mx) c = mx;
        return {e.w[31:24], 24'(c)};
    endfunction

    always @(negedge clk) begin
        bit tk, bz;
        ent_t e;
        bz = (mq.size() != 0);
        chk("valid", 32'(out_valid), 32'(bz));
        chk("busy", 32'(busy), 32'(bz));
        chk("valid4", 32'(out_valid4), 32'(bz));
        if (bz) begin
            chk("data", out_data, expw(mq[0], 16));
            chk("data4", out_data4, expw(mq[0], 4));
        end else if (m_fresh) begin
            chk("rst_data", out_data, 32'd0);
        end
        if (out_valid && out_ready) begin
            cap.push_back(out_data);
            cap4.push_back(out_data4);
        end
        if (rst) begin
            mq.delete();
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_timer = 0; m_seq = 0; m_ovr = 0; m_ovr_new = 0; m_fresh = 1;
        end else begin
            tk = (period != 0) && (m_timer >= period - 1);
            if (bz && out_ready) begin
                e = mq.pop_front();
                if (e.hdr) m_ovr = m_ovr_new;
            end
            if (tk && bz) begin
                m_ovr = 1; m_ovr_new = 1;
            end
            if (tk && !bz) begin
                mq.push_back('{hdr: 1'b1, w: {4'hA, m_ovr, 11'b0, m_seq}});
                m_seq++;
                for (int i = 0; i < NC; i++) begin
                    mq.push_back('{hdr: 1'b0, w: {8'(i), 24'(m_cnt[i])}});
                    m_cnt[i] = 0;
                end
                m_ovr_new = 0;
                m_fresh = 0;
            end
            if (enable[0]) m_cnt[0]++;
            if (enable[1]) m_cnt[1]++;
            if (enable[2]) m_cnt[2 + 2 * int'(ep)]++;
            if (enable[3]) m_cnt[3 + 2 * int'(ep)]++;
            m_timer = (period == 0 || tk) ? 0 : m_timer + 1;
        end
    end

    task automatic step(input logic [3:0] en, input logic [1:0] e);
        enable = en;
        ep = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'd0, 2'd0);
    endtask

    function automatic logic [3:0] rnd_en();
        int r;
        r = $urandom_range(0, 7);
        return (r < 4) ? 4'(1 << r) : 4'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", out_data, 32'd0);
        cap.delete();
        cap4.delete();
    endtask

    function automatic logic [31:0] at(input int i);
        return (cap.size() > i) ? cap[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        int k, nv;
        @(posedge clk);
        #1;

        // basic interval with mixed strobes, two consecutive snapshots
        period = 100; out_ready = 1'b1;
        do_reset();
        repeat (3) begin step(4'b0001, 2'd0); step(4'd0, 2'd0); end
        repeat (2) step(4'b0100, 2'd1);
        repeat (5) step(4'b1000, 2'd3);
        idle(250);
        chk("p1_hdr0", at(0), 32'hA0000000);
        chk("p1_w0", at(1), 32'h00000003);
        chk("p1_w1", at(2), 32'h01000000);
        chk("p1_w4", at(5), 32'h04000002);
        chk("p1_w9", at(10), 32'h09000005);
        chk("p1_hdr1", at(11), 32'hA0000001);

        // saturation on the narrow instance
        do_reset();
        repeat (20) step(4'b0010, 2'd0);
        idle(130);
        chk("p2_sat4", (cap4.size() > 2) ? cap4[2] : 32'hxxxxxxxx, 32'h0100000F);
        chk("p2_nosat16", at(2), 32'h01000014);

        // strobe exactly in the tick cycle
        period = 20;
        do_reset();
        k = 0;
        while (m_timer != 32'd19 && k < 40) begin idle(1); k++; end
        step(4'b0100, 2'd0);
        idle(60);
        chk("p3_snap0", at(3), 32'h02000000);
        chk("p3_hdr1", at(11), 32'hA0000001);
        chk("p3_snap1", at(14), 32'h02000001);

        // downstream stall across several ticks
        period = 10; out_ready = 1'b0;
        do_reset();
        repeat (40) begin
            step(rnd_en(), 2'($urandom_range(0, 3)));
            if (out_valid) chk("p4_stall", out_data, 32'hA0000000);
        end
        out_ready = 1'b1;
        idle(60);
        chk("p4_hdr0", at(0), 32'hA0000000);
        chk("p4_hdr1", at(11), 32'hA8000001);

        // sampling disabled, then enabled
        period = 0;
        do_reset();
        nv = 0;
        repeat (1000) begin
            step(rnd_en(), 2'($urandom_range(0, 3)));
            if (out_valid) nv++;
        end
        chk("p5_novalid", 32'(nv), 32'd0);
        period = 5;
        k = 0;
        while (!out_valid && k < 20) begin idle(1); k++; end
        chk("p5_latency", 32'(k <= 6), 32'd1);
        idle(20);

        // reset in the middle of the data words
        period = 20;
        do_reset();
        k = 0;
        while (cap.size() < 4 && k < 100) begin idle(1); k++; end
        chk("p6_reach_idx3", 32'(cap.size()), 32'd4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("p6_valid", 32'(out_valid), 32'd0);
        chk("p6_busy", 32'(busy), 32'd0);
        cap.delete();
        cap4.delete();
        idle(40);
        chk("p6_hdr", at(0), 32'hA0000000);

        // random traffic, backpressure and period changes
        period = 25;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 5))
                    0: period = 0;
                    1: period = 3;
                    2: period = 7;
                    3: period = 12;
                    4: period = 25;
                    default: period = 40;
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(rnd_en(), 2'($urandom_range(0, 3)));
        end
        out_ready = 1'b1;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
